// File: rtl/ysyx_22050078_bru_bp.sv
// Fetch-PC owner with BTB + 2-bit counter next-PC prediction and EX-stage branch/jump resolution.
// Latency: lookup and resolve/flush/redirect are combinational (0 cycles); PC, BTB and perf state update on the next edge.
// Backpressure: i_pcwen=0 holds the PC; a mispredict flush always redirects the PC, overriding the stall.
module ysyx_22050078_bru_bp #(
    parameter int                XLEN      = 64,
    parameter int                BTB_DEPTH = 16,
    parameter int                TAG_W     = 12,
    parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(64'h80000000),
    parameter int                PERF_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pcwen,
    output logic [XLEN-1:0]     o_pc,
    output logic                o_pred_taken,
    output logic [XLEN-1:0]     o_pred_target,
    input  logic                i_ex_valid,
    input  logic                i_brch,
    input  logic                i_jal,
    input  logic                i_jalr,
    input  logic [2:0]          i_bfunc3,
    input  logic [XLEN-1:0]     i_rs1_data,
    input  logic [XLEN-1:0]     i_rs2_data,
    input  logic [XLEN-1:0]     i_imm,
    input  logic [XLEN-1:0]     i_ex_pc,
    input  logic                i_ex_pred_taken,
    input  logic [XLEN-1:0]     i_ex_pred_target,
    output logic                o_flush,
    output logic [XLEN-1:0]     o_redirect_pc,
    output logic [PERF_W-1:0]   o_perf_ctrl,
    output logic [PERF_W-1:0]   o_perf_mispred
);

    localparam int IDX_W = $clog2(BTB_DEPTH);

    // Branch funct3 encodings; 3'b010 and 3'b011 are undefined and resolve not-taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit counter values: MSB set means "predict taken".
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   target;
        logic [1:0]        ctr;
    } btb_entry_t;

    // Architectural state
    logic [XLEN-1:0]    pc_q;
    btb_entry_t         btb_q [BTB_DEPTH];
    logic [PERF_W-1:0]  perf_ctrl_q;
    logic [PERF_W-1:0]  perf_mispred_q;

    // Fetch-side lookup
    logic [XLEN-1:0]    pc_inc;
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    // EX-side resolution
    logic [XLEN:0]      sub_res;
    logic               cmp_eq;
    logic               cmp_lt;
    logic               cmp_ltu;
    logic               br_cond;
    logic               is_ctrl;
    logic               is_jump;
    logic               act_taken;
    logic [XLEN-1:0]    ex_inc;
    logic [XLEN-1:0]    jalr_sum;
    logic [XLEN-1:0]    br_target;
    logic [XLEN-1:0]    act_next;
    logic [XLEN-1:0]    pred_next;

    // BTB training
    logic               up_vld;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    btb_entry_t         up_ent;
    logic               up_hit;
    logic               up_we;
    btb_entry_t         up_nxt;

    assign o_pc           = pc_q;
    assign o_perf_ctrl    = perf_ctrl_q;
    assign o_perf_mispred = perf_mispred_q;

    // Predict the next fetch PC from the BTB entry selected by the current PC.
    always_comb begin
        pc_inc        = pc_q + XLEN'(4);
        lk_idx        = pc_q[IDX_W+1:2];
        lk_tag        = pc_q[IDX_W+2 +: TAG_W];
        lk_hit        = btb_q[lk_idx].vld && (btb_q[lk_idx].tag == lk_tag);
        o_pred_taken  = lk_hit && btb_q[lk_idx].ctr[1];
        o_pred_target = lk_hit ? btb_q[lk_idx].target : pc_inc;
    end

    // Evaluate branch conditions from one (XLEN+1)-bit subtraction.
    always_comb begin
        sub_res = {1'b0, i_rs1_data} - {1'b0, i_rs2_data};
        cmp_eq  = ~|sub_res[XLEN-1:0];
        // Borrow out of the zero-extended subtraction means rs1 < rs2 unsigned.
        cmp_ltu = sub_res[XLEN];
        // Differing signs cannot overflow-compare via the difference: the negative one is smaller.
        cmp_lt  = (i_rs1_data[XLEN-1] != i_rs2_data[XLEN-1]) ? i_rs1_data[XLEN-1]
                                                             : sub_res[XLEN-1];
        case (i_bfunc3)
            F3_BEQ:  br_cond = cmp_eq;
            F3_BNE:  br_cond = ~cmp_eq;
            F3_BLT:  br_cond = cmp_lt;
            F3_BGE:  br_cond = ~cmp_lt;
            F3_BLTU: br_cond = cmp_ltu;
            F3_BGEU: br_cond = ~cmp_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    // Resolve the EX instruction's real next PC and compare with what fetch assumed.
    always_comb begin
        is_jump   = i_jal | i_jalr;
        is_ctrl   = i_brch | is_jump;
        act_taken = (i_brch & br_cond) | is_jump;
        ex_inc    = i_ex_pc + XLEN'(4);
        jalr_sum  = i_rs1_data + i_imm;
        br_target = i_jalr ? (jalr_sum & ~XLEN'(1)) : (i_ex_pc + i_imm);
        act_next  = act_taken ? br_target : ex_inc;
        pred_next = i_ex_pred_taken ? i_ex_pred_target : ex_inc;
        // Compares full next-PC, so a non-control instruction predicted taken (alias) also flushes.
        o_flush       = i_rst_n & i_ex_valid & (act_next != pred_next);
        o_redirect_pc = act_next;
    end

    // Compute the trained BTB entry for the resolved control transfer.
    always_comb begin
        up_vld = i_ex_valid & is_ctrl;
        up_idx = i_ex_pc[IDX_W+1:2];
        up_tag = i_ex_pc[IDX_W+2 +: TAG_W];
        up_ent = btb_q[up_idx];
        up_hit = up_ent.vld && (up_ent.tag == up_tag);
        up_we  = 1'b0;
        up_nxt = up_ent;
        if (up_vld) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (is_jump) begin
                    up_nxt.ctr = CTR_ST;
                end else if (act_taken) begin
                    up_nxt.ctr = (up_ent.ctr == CTR_ST) ? CTR_ST : up_ent.ctr + 2'd1;
                end else begin
                    up_nxt.ctr = (up_ent.ctr == CTR_SNT) ? CTR_SNT : up_ent.ctr - 2'd1;
                end
                if (act_taken) begin
                    up_nxt.target = br_target;
                end
            end else if (act_taken) begin
                // Not-taken misses are never allocated: they would only predict fall-through.
                up_we  = 1'b1;
                up_nxt = '{vld: 1'b1, tag: up_tag, target: br_target,
                           ctr: (is_jump ? CTR_ST : CTR_WT)};
            end
        end
    end

    // PC register: a flush wins over the stall, otherwise follow the prediction when enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else if (o_flush) begin
            pc_q <= o_redirect_pc;
        end else if (i_pcwen) begin
            pc_q <= o_pred_taken ? o_pred_target : pc_inc;
        end
    end

    // BTB storage; the lookup above reads the pre-update entry on a same-index collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_q[i] <= '{vld: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (up_we) begin
            btb_q[up_idx] <= up_nxt;
        end
    end

    // Wrapping performance counters for resolved control transfers and mispredicts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_ctrl_q    <= '0;
            perf_mispred_q <= '0;
        end else begin
            perf_ctrl_q    <= perf_ctrl_q + PERF_W'(up_vld);
            perf_mispred_q <= perf_mispred_q + PERF_W'(o_flush);
        end
    end

endmodule

// File: tb/tb_ysyx_22050078_bru_bp.sv
// Bench for the branch unit / predictor: reference model checked every negedge plus directed literal checks.
// Latency: outputs compared half a cycle after inputs are applied; state compared after each edge.
// Backpressure: exercises i_pcwen stalls against flush redirects.
`timescale 1ns/1ps
module tb_ysyx_22050078_bru_bp;

    localparam int          DEPTH  = 16;
    localparam int          IDXW   = 4;
    localparam int          TAGW   = 12;
    localparam logic [63:0] RST_PC = 64'h80000000;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pcwen = 1'b1;
    logic [63:0] o_pc;
    logic        o_pred_taken;
    logic [63:0] o_pred_target;
    logic        i_ex_valid = 1'b0;
    logic        i_brch = 1'b0;
    logic        i_jal = 1'b0;
    logic        i_jalr = 1'b0;
    logic [2:0]  i_bfunc3 = 3'd0;
    logic [63:0] i_rs1_data = '0;
    logic [63:0] i_rs2_data = '0;
    logic [63:0] i_imm = '0;
    logic [63:0] i_ex_pc = '0;
    logic        i_ex_pred_taken = 1'b0;
    logic [63:0] i_ex_pred_target = '0;
    logic        o_flush;
    logic [63:0] o_redirect_pc;
    logic [31:0] o_perf_ctrl;
    logic [31:0] o_perf_mispred;

    always #5 i_clk = ~i_clk;

    ysyx_22050078_bru_bp dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pcwen(i_pcwen),
        .o_pc(o_pc), .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .i_ex_valid(i_ex_valid), .i_brch(i_brch), .i_jal(i_jal), .i_jalr(i_jalr),
        .i_bfunc3(i_bfunc3), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_ex_pc(i_ex_pc), .i_ex_pred_taken(i_ex_pred_taken),
        .i_ex_pred_target(i_ex_pred_target), .o_flush(o_flush),
        .o_redirect_pc(o_redirect_pc), .o_perf_ctrl(o_perf_ctrl),
        .o_perf_mispred(o_perf_mispred)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_vld [DEPTH];
    logic [TAGW-1:0] m_tag [DEPTH];
    logic [63:0]     m_tgt [DEPTH];
    int              m_ctr [DEPTH];
    logic [63:0]     m_pc;
    logic [31:0]     m_pctrl;
    logic [31:0]     m_pmis;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'(DEPTH));
    endfunction

    function automatic logic [TAGW-1:0] tag_of(input logic [63:0] pc);
        return TAGW'(pc >> (IDXW + 2));
    endfunction

    task automatic predict(output bit hit, output bit taken, output logic [63:0] tgt);
        int i;
        i     = idx_of(m_pc);
        hit   = m_vld[i] && (m_tag[i] == tag_of(m_pc));
        taken = hit && (m_ctr[i] >= 2);
        tgt   = hit ? m_tgt[i] : m_pc + 64'd4;
    endtask

    task automatic resolve(output bit ctrl, output bit taken, output logic [63:0] target,
                           output logic [63:0] actual, output bit flush);
        bit          c;
        logic [63:0] pred;
        case (i_bfunc3)
            3'd0:    c = (i_rs1_data == i_rs2_data);
            3'd1:    c = (i_rs1_data != i_rs2_data);
            3'd4:    c = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            3'd5:    c = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            3'd6:    c = (i_rs1_data <  i_rs2_data);
            3'd7:    c = (i_rs1_data >= i_rs2_data);
            default: c = 1'b0;
        endcase
        ctrl   = i_brch || i_jal || i_jalr;
        taken  = (i_brch && c) || i_jal || i_jalr;
        target = i_jalr ? ((i_rs1_data + i_imm) & ~64'd1) : (i_ex_pc + i_imm);
        actual = taken ? target : i_ex_pc + 64'd4;
        pred   = i_ex_pred_taken ? i_ex_pred_target : i_ex_pc + 64'd4;
        flush  = i_rst_n && i_ex_valid && (actual != pred);
    endtask

    // Model state advance on each edge (and on async reset).
    always @(posedge i_clk or negedge i_rst_n) begin
        bit          p_hit, p_tk, r_ctrl, r_tk, r_fl, u_hit;
        logic [63:0] p_tgt, r_tgt, r_act;
        int          u;
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_vld[i] <= 1'b0;
                m_ctr[i] <= 1;
            end
            m_pc    <= RST_PC;
            m_pctrl <= '0;
            m_pmis  <= '0;
        end else begin
            predict(p_hit, p_tk, p_tgt);
            resolve(r_ctrl, r_tk, r_tgt, r_act, r_fl);
            if (r_fl)         m_pc <= r_act;
            else if (i_pcwen) m_pc <= p_tk ? p_tgt : m_pc + 64'd4;
            if (i_ex_valid && r_ctrl) begin
                u     = idx_of(i_ex_pc);
                u_hit = m_vld[u] && (m_tag[u] == tag_of(i_ex_pc));
                if (u_hit) begin
                    if (i_jal || i_jalr) m_ctr[u] <= 3;
                    else if (r_tk)       m_ctr[u] <= (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
                    else                 m_ctr[u] <= (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                    if (r_tk) m_tgt[u] <= r_tgt;
                end else if (r_tk) begin
                    m_vld[u] <= 1'b1;
                    m_tag[u] <= tag_of(i_ex_pc);
                    m_tgt[u] <= r_tgt;
                    m_ctr[u] <= (i_jal || i_jalr) ? 3 : 2;
                end
                m_pctrl <= m_pctrl + 32'd1;
            end
            if (r_fl) m_pmis <= m_pmis + 32'd1;
        end
    end

    // Compare every DUT output to the model in the middle of each cycle.
    always @(negedge i_clk) begin
        bit          p_hit, p_tk, r_ctrl, r_tk, r_fl;
        logic [63:0] p_tgt, r_tgt, r_act;
        predict(p_hit, p_tk, p_tgt);
        resolve(r_ctrl, r_tk, r_tgt, r_act, r_fl);
        chk("m_pc",          o_pc, m_pc);
        chk("m_pred_taken",  64'(o_pred_taken), 64'(p_tk));
        chk("m_pred_target", o_pred_target, p_tgt);
        chk("m_flush",       64'(o_flush), 64'(r_fl));
        if (r_fl) chk("m_redirect", o_redirect_pc, r_act);
        chk("m_perf_ctrl",   64'(o_perf_ctrl), 64'(m_pctrl));
        chk("m_perf_mis",    64'(o_perf_mispred), 64'(m_pmis));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        i_ex_valid = 1'b0; i_brch = 1'b0; i_jal = 1'b0; i_jalr = 1'b0;
        i_bfunc3 = 3'd0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
        i_ex_pc = '0; i_ex_pred_taken = 1'b0; i_ex_pred_target = '0;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] imm, input logic [63:0] pc,
                          input logic ptk, input logic [63:0] ptgt);
        set_idle();
        i_ex_valid = 1'b1; i_brch = 1'b1; i_bfunc3 = f3;
        i_rs1_data = a; i_rs2_data = b; i_imm = imm; i_ex_pc = pc;
        i_ex_pred_taken = ptk; i_ex_pred_target = ptgt;
    endtask

    // Non-control instruction falsely predicted taken: redirects fetch to dst without BTB training.
    task automatic set_steer(input logic [63:0] dst);
        set_idle();
        i_ex_valid = 1'b1; i_ex_pc = dst - 64'd4;
        i_ex_pred_taken = 1'b1; i_ex_pred_target = dst + 64'h1000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_ctrl, snap_mis;
        set_idle();
        i_pcwen = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pc",        o_pc, RST_PC);
        chk("rst_pred",      64'(o_pred_taken), 64'd0);
        chk("rst_flush",     64'(o_flush), 64'd0);
        chk("rst_perf_ctrl", 64'(o_perf_ctrl), 64'd0);
        i_rst_n = 1'b1;
        step();
        chk("rel_pc", o_pc, 64'h80000004);

        // Cold BEQ taken
        set_br(3'd0, 64'd5, 64'd5, 64'h20, 64'h80000010, 1'b0, 64'h80000014);
        #1;
        chk("beq_flush",    64'(o_flush), 64'd1);
        chk("beq_redirect", o_redirect_pc, 64'h80000030);
        step();
        chk("beq_pc", o_pc, 64'h80000030);
        set_steer(64'h80000010);
        step();
        set_idle();
        #1;
        chk("beq_fetch_pc",  o_pc, 64'h80000010);
        chk("beq_pred_tk",   64'(o_pred_taken), 64'd1);
        chk("beq_pred_tgt",  o_pred_target, 64'h80000030);

        // Counter saturation on one BNE
        set_br(3'd1, 64'd1, 64'd2, 64'h40, 64'h80000048, 1'b0, 64'd0);
        #1; chk("bne1_flush", 64'(o_flush), 64'd1);
        step();
        set_br(3'd1, 64'd1, 64'd2, 64'h40, 64'h80000048, 1'b1, 64'h80000088);
        #1; chk("bne2_flush", 64'(o_flush), 64'd0);
        step();
        step();
        set_br(3'd1, 64'd3, 64'd3, 64'h40, 64'h80000048, 1'b1, 64'h80000088);
        #1;
        chk("bne4_flush",    64'(o_flush), 64'd1);
        chk("bne4_redirect", o_redirect_pc, 64'h8000004C);
        step();
        set_steer(64'h80000048);
        step();
        set_idle();
        #1;
        chk("ctr10_pred_tk",  64'(o_pred_taken), 64'd1);
        chk("ctr10_pred_tgt", o_pred_target, 64'h80000088);
        step();
        set_br(3'd1, 64'd3, 64'd3, 64'h40, 64'h80000048, 1'b1, 64'h80000088);
        step();
        set_steer(64'h80000048);
        step();
        set_idle();
        #1;
        chk("ctr01_pred_tk",  64'(o_pred_taken), 64'd0);
        chk("ctr01_pred_tgt", o_pred_target, 64'h80000088);
        step();

        // Signed / unsigned compares
        set_br(3'd4, ALL1, 64'd1, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("blt_neg_flush", 64'(o_flush), 64'd1);
        chk("blt_neg_redir", o_redirect_pc, 64'h80000380);
        step();
        set_br(3'd6, ALL1, 64'd1, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("bltu_flush", 64'(o_flush), 64'd0);
        chk("bltu_next", o_redirect_pc, 64'h80000304);
        step();
        set_br(3'd4, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("blt_ovf_flush", 64'(o_flush), 64'd1);
        chk("blt_ovf_redir", o_redirect_pc, 64'h80000380);
        step();
        set_br(3'd5, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("bge_ovf_flush", 64'(o_flush), 64'd0);
        step();
        set_br(3'd2, 64'd7, 64'd7, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("f3_undef_flush", 64'(o_flush), 64'd0);
        step();
        set_br(3'd7, ALL1, 64'd1, 64'h80, 64'h80000300, 1'b0, 64'd0);
        #1; chk("bgeu_flush", 64'(o_flush), 64'd1);
        step();

        // JALR alignment under stall
        set_idle();
        i_pcwen = 1'b0;
        i_ex_valid = 1'b1; i_jalr = 1'b1;
        i_rs1_data = 64'h80001001; i_imm = 64'h10; i_ex_pc = 64'h80000400;
        #1;
        chk("jalr_flush",    64'(o_flush), 64'd1);
        chk("jalr_redirect", o_redirect_pc, 64'h80001010);
        step();
        chk("jalr_pc", o_pc, 64'h80001010);
        set_idle();
        step();
        chk("stall_hold_pc", o_pc, 64'h80001010);
        i_pcwen = 1'b1;

        // Aliased prediction on a non-control instruction
        snap_ctrl = m_pctrl;
        snap_mis  = m_pmis;
        set_idle();
        i_ex_valid = 1'b1; i_ex_pc = 64'h80000100;
        i_ex_pred_taken = 1'b1; i_ex_pred_target = 64'h80002000;
        #1;
        chk("alias_flush",    64'(o_flush), 64'd1);
        chk("alias_redirect", o_redirect_pc, 64'h80000104);
        step();
        chk("alias_pc",       o_pc, 64'h80000104);
        chk("alias_mispred",  64'(o_perf_mispred), 64'(snap_mis + 32'd1));
        chk("alias_ctrl",     64'(o_perf_ctrl), 64'(snap_ctrl));
        set_idle();
        step();

        // Mid-run asynchronous reset
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",   o_pc, RST_PC);
        chk("mid_rst_pred", 64'(o_pred_taken), 64'd0);
        chk("mid_rst_ctrl", 64'(o_perf_ctrl), 64'd0);
        chk("mid_rst_mis",  64'(o_perf_mispred), 64'd0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("mid_rel_pc", o_pc, 64'h80000004);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
